// File: rtl/enemy_y_tracker.sv
// enemy_y_tracker: N_CH independent enemy channels whose y position advances on a shared,
// rate-selectable motion tick, clamping at Y_MAX and then either wrapping or retiring.
module enemy_y_tracker #(
  parameter int N_CH   = 10,
  parameter int Y_W    = 8,
  parameter int Y_MAX  = 120,
  parameter int TICK_W = 24,
  parameter int RATE0  = 12499999,
  parameter int RATE1  = 6499999,
  parameter int RATE2  = 3999999,
  parameter int RATE3  = 1999999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              move_en,
  input  logic [1:0]        flying_rate,
  input  logic [1:0]        step,
  input  logic              wrap_mode,
  input  logic [N_CH-1:0]   spawn,
  input  logic [N_CH-1:0]   destroyed,
  output logic [N_CH*Y_W-1:0] y_flat,
  output logic [N_CH-1:0]   active,
  output logic [N_CH-1:0]   touch_edge,
  output logic              move
);
  localparam logic [TICK_W-1:0] L0 = TICK_W'(RATE0);
  localparam logic [TICK_W-1:0] L1 = TICK_W'(RATE1);
  localparam logic [TICK_W-1:0] L2 = TICK_W'(RATE2);
  localparam logic [TICK_W-1:0] L3 = TICK_W'(RATE3);
  localparam logic [Y_W:0]      Y_LIM = (Y_W+1)'(Y_MAX);
  typedef enum logic {IDLE, FLY} state_t;
  logic [TICK_W-1:0] r_cnt;
  logic [TICK_W-1:0] w_limit;
  logic              w_tick;
  always_comb
    w_limit = flying_rate == 2'd0 ? L0 : flying_rate == 2'd1 ? L1 : flying_rate == 2'd2 ? L2 : L3;
  // the >= compare lets a rate change to a shorter limit fire on the very same cycle
  assign w_tick = r_cnt >= w_limit;
  assign move   = move_en & w_tick;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      r_cnt <= '0;
    else if (move_en)
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t         r_state;
    logic [Y_W-1:0] r_y;
    logic           r_touch;
    logic [Y_W:0]   w_sum;
    assign w_sum = {1'b0, r_y} + (Y_W+1)'(step) + (Y_W+1)'(1);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_state <= IDLE;
        r_y     <= '0;
        r_touch <= 1'b0;
      end else begin
        r_touch <= 1'b0;
        if (r_state == IDLE) begin
          r_y <= '0;
          if (spawn[i]) r_state <= FLY;
        end else if (destroyed[i]) begin
          r_state <= IDLE;
          r_y     <= '0;
        end else if (move) begin
          if ({1'b0, r_y} < Y_LIM) begin
            r_y     <= w_sum >= Y_LIM ? Y_LIM[Y_W-1:0] : w_sum[Y_W-1:0];
            r_touch <= w_sum >= Y_LIM;
          end else begin
            r_y <= '0;
            if (!wrap_mode) r_state <= IDLE;
          end
        end
      end
    assign y_flat[i*Y_W +: Y_W] = r_y;
    assign active[i]            = r_state == FLY;
    assign touch_edge[i]        = r_touch;
  end
endmodule

// File: doc/enemy_y_tracker.md
ENEMY_Y_TRACKER -- requirements
Module: enemy_y_tracker

Interface
REQ-001 SHALL have parameter N_CH, default 10, number of enemy channels.
REQ-002 SHALL have parameter Y_W, default 8, y coordinate width.
REQ-003 SHALL have parameter Y_MAX, default 120, bottom-edge y value (must be < 2^Y_W).
REQ-004 SHALL have parameter TICK_W, default 24, tick counter width.
REQ-005 SHALL have parameters RATE0..RATE3, defaults 12499999, 6499999, 3999999, 1999999, tick limits.
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port move_en  in  1  global tick enable; low pauses all motion.
REQ-009 SHALL have port flying_rate  in  2  selects limit RATE0..RATE3.
REQ-010 SHALL have port step  in  2  y increment per tick = step+1 (1..4).
REQ-011 SHALL have port wrap_mode  in  1  1: channel restarts at y=0 after edge; 0: channel retires.
REQ-012 SHALL have port spawn  in  N_CH  per-channel launch request.
REQ-013 SHALL have port destroyed  in  N_CH  per-channel kill.
REQ-014 SHALL have port y_flat  out  N_CH*Y_W  y of channel i at bits [i*Y_W +: Y_W].
REQ-015 SHALL have port active  out  N_CH  channel i in FLY state.
REQ-016 SHALL have port touch_edge  out  N_CH  one-cycle pulse, channel reached Y_MAX.
REQ-017 SHALL have port move  out  1  global tick pulse.

Function
REQ-018 Tick counter cnt SHALL, when move_en=1, reset to 0 if cnt >= limit(flying_rate), else increment; hold when move_en=0.
REQ-019 move SHALL be combinational: move_en & (cnt >= limit); period = limit+1 enabled cycles.
REQ-020 flying_rate change SHALL take effect immediately; if cnt already >= new limit, move asserts that cycle.
REQ-021 Each channel SHALL be an FSM with states IDLE and FLY; active = (state==FLY).
REQ-022 IDLE: y SHALL be 0; spawn[i]=1 -> FLY with y=0 next cycle; destroyed[i] ignored.
REQ-023 FLY priority SHALL be destroyed > move; spawn ignored in FLY.
REQ-024 FLY & destroyed[i] -> IDLE, y=0 next cycle, no touch_edge.
REQ-025 FLY & move & y<Y_MAX: sum = y+step+1 computed Y_W+1 wide; sum >= Y_MAX -> y=Y_MAX and touch_edge[i]=1 next cycle; else y=sum.
REQ-026 touch_edge[i] SHALL be registered, high exactly one cycle per arrival at Y_MAX.
REQ-027 FLY & move & y==Y_MAX: wrap_mode=1 -> y=0, stay FLY; wrap_mode=0 -> IDLE, y=0.
REQ-028 move_en=0 SHALL freeze cnt and all y values; spawn and destroyed still act.
REQ-029 Channels SHALL be independent; all share one move tick and step.

Reset
REQ-030 reset_n=0 SHALL asynchronously force cnt=0, all channels IDLE, y_flat=0, active=0, touch_edge=0.
REQ-031 Reset asserted mid-flight SHALL abort all channels; no touch_edge on exit from reset.
REQ-032 First move after reset release SHALL occur after limit+1 cycles with move_en=1.

Verification (N_CH=4, Y_MAX=10, RATE0..3=3,2,1,0)
REQ-033 flying_rate=0, move_en=1 from reset -> move high on cycles 4, 8, 12 (one cycle each).
REQ-034 spawn[0], step=0, rate=3 -> y0 counts 1..10 one per cycle; touch_edge[0] pulses once when y0=10; wrap_mode=0 -> next tick y0=0, active[0]=0.
REQ-035 step=3, wrap_mode=1, rate=3 -> y 0,4,8,10 (clamped, touch_edge pulse),0,4; active stays 1.
REQ-036 destroyed[1] and move same cycle at y1=6 -> y1=0, active[1]=0, no touch_edge; spawn+destroyed in IDLE -> FLY.
REQ-037 move_en low 5 cycles mid-flight -> cnt and y frozen, resume unchanged; reset_n pulse mid-cycle -> all outputs 0 immediately.
